sonic_blocksync_ctrl: RTL and testbench

SONIC_BLOCKSYNC_CTRL -- requirements
Module: sonic_blocksync_ctrl

---
 rtl/sonic_blocksync_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sonic_blocksync_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sonic_blocksync_ctrl.sv
// rtl/sonic_blocksync_ctrl.sv - 64b/66b block alignment FSM with slip handshake and BER monitor
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   reset      : asynchronous, active-high reset
//   valid      : one aligned 66-bit block presented by the barrel shifter this cycle
//   sh_valid   : sync header of the presented block is 01 or 10 (qualified by valid)
//   slip_ack   : one-cycle pulse from the barrel shifter, offset advanced by one bit
//   slip_req   : request a one-bit slip, held high until slip_ack
//   block_lock : block alignment achieved
//   hi_ber     : high bit-error-rate condition while locked
//   slip_count : slips since last lock or reset, sweeps 0..65 then wraps to 0

module sonic_blocksync_ctrl #(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SETTLE_CNT  = 2,
  parameter int BER_WINDOW  = 31250,
  parameter int BER_THRESH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       sh_valid,
  input  logic       slip_ack,
  output logic       slip_req,
  output logic       block_lock,
  output logic       hi_ber,
  output logic [6:0] slip_count
);

  localparam int WW  = $clog2(BER_WINDOW + 1);
  localparam int BCW = $clog2(BER_THRESH + 1);

  localparam logic [6:0]     LOCK_V    = 7'(LOCK_CNT);
  localparam logic [6:0]     SETTLE_V  = 7'(SETTLE_CNT);
  localparam logic [6:0]     SLIP_LAST = 7'd65;
  localparam logic [4:0]     INV_V     = 5'(INVALID_MAX);
  localparam logic [WW-1:0]  WIN_V     = WW'(BER_WINDOW);
  localparam logic [BCW-1:0] THR_V     = BCW'(BER_THRESH);

  typedef enum logic [1:0] {HUNT, SLIP, SETTLE, LOCKED} state_t;

  state_t         state, state_nx;
  logic [6:0]     sh_cnt, sh_cnt_nx;
  logic [4:0]     inv_cnt, inv_cnt_nx;
  logic [6:0]     slip_count_nx;
  logic [WW-1:0]  ber_win, ber_win_nx;
  logic [BCW-1:0] ber_cnt, ber_cnt_nx;
  logic           hi_ber_nx;

  logic [6:0]     sh_inc;
  logic [4:0]     inv_inc;
  logic [WW-1:0]  ber_win_inc;
  logic [BCW-1:0] ber_cnt_inc;

  assign sh_inc      = sh_cnt + 7'd1;
  assign inv_inc     = inv_cnt + {4'd0, ~sh_valid};
  assign ber_win_inc = ber_win + WW'(1);
  // BER error count saturates at the threshold
  assign ber_cnt_inc = (sh_valid || ber_cnt == THR_V) ? ber_cnt : ber_cnt + BCW'(1);

  // Outputs decode directly from the registered state
  assign slip_req   = (state == SLIP);
  assign block_lock = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      slip_count <= '0;
      ber_win    <= '0;
      ber_cnt    <= '0;
      hi_ber     <= 1'b0;
    end else begin
      state      <= state_nx;
      sh_cnt     <= sh_cnt_nx;
      inv_cnt    <= inv_cnt_nx;
      slip_count <= slip_count_nx;
      ber_win    <= ber_win_nx;
      ber_cnt    <= ber_cnt_nx;
      hi_ber     <= hi_ber_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    sh_cnt_nx     = sh_cnt;
    inv_cnt_nx    = inv_cnt;
    slip_count_nx = slip_count;
    ber_win_nx    = ber_win;
    ber_cnt_nx    = ber_cnt;
    hi_ber_nx     = hi_ber;

    case (state)
      HUNT: begin
        if (valid) begin
          if (!sh_valid) begin
            state_nx   = SLIP;
            sh_cnt_nx  = '0;
            inv_cnt_nx = '0;
          end else if (sh_inc == LOCK_V) begin
            state_nx      = LOCKED;
            sh_cnt_nx     = '0;
            inv_cnt_nx    = '0;
            slip_count_nx = '0;
          end else begin
            sh_cnt_nx = sh_inc;
          end
        end
      end

      // Blocks seen while waiting for the shifter are misaligned; ignore them
      SLIP: begin
        if (slip_ack) begin
          state_nx      = SETTLE;
          slip_count_nx = (slip_count == SLIP_LAST) ? 7'd0 : slip_count + 7'd1;
        end
      end

      // sh_cnt doubles as the discard counter while the shifter pipeline refills
      SETTLE: begin
        if (valid) begin
          if (sh_inc >= SETTLE_V) begin
            state_nx  = HUNT;
            sh_cnt_nx = '0;
          end else begin
            sh_cnt_nx = sh_inc;
          end
        end
      end

      LOCKED: begin
        if (valid) begin
          if (inv_inc == INV_V) begin
            // Lock loss takes priority over any window end on this block
            state_nx   = SLIP;
            sh_cnt_nx  = '0;
            inv_cnt_nx = '0;
            ber_win_nx = '0;
            ber_cnt_nx = '0;
            hi_ber_nx  = 1'b0;
          end else begin
            if (sh_inc == LOCK_V) begin
              sh_cnt_nx  = '0;
              inv_cnt_nx = '0;
            end else begin
              sh_cnt_nx  = sh_inc;
              inv_cnt_nx = inv_inc;
            end
            if (ber_win_inc == WIN_V) begin
              hi_ber_nx  = (ber_cnt_inc == THR_V);
              ber_win_nx = '0;
              ber_cnt_nx = '0;
            end else begin
              ber_win_nx = ber_win_inc;
              ber_cnt_nx = ber_cnt_inc;
              if (ber_cnt_inc == THR_V) hi_ber_nx = 1'b1;
            end
          end
        end
      end

      default: state_nx = HUNT;
    endcase
  end

endmodule

// File: tb/tb_sonic_blocksync_ctrl.sv
// tb/tb_sonic_blocksync_ctrl.sv - table-driven bench for sonic_blocksync_ctrl

module tb_sonic_blocksync_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic       sh_valid = 1'b0;
  logic       slip_ack = 1'b0;
  logic       slip_req;
  logic       block_lock;
  logic       hi_ber;
  logic [6:0] slip_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sonic_blocksync_ctrl #(
    .LOCK_CNT(64), .INVALID_MAX(16), .SETTLE_CNT(2),
    .BER_WINDOW(100), .BER_THRESH(16)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .sh_valid(sh_valid),
    .slip_ack(slip_ack), .slip_req(slip_req), .block_lock(block_lock),
    .hi_ber(hi_ber), .slip_count(slip_count)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic       a;
    int         n;
    logic       req;
    logic       lock;
    logic       hi;
    logic [6:0] sc;
  } vec_t;

  vec_t tbl [14];

  task automatic blk(input logic v, input logic s, input logic a);
    valid = v; sh_valid = s; slip_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic req, input logic lock,
                       input logic hi, input logic [6:0] sc);
    checks++;
    if ({slip_req, block_lock, hi_ber, slip_count} !== {req, lock, hi, sc}) begin
      errors++;
      $display("FAIL %s: got req=%b lock=%b hi=%b sc=%0d, expected req=%b lock=%b hi=%b sc=%0d",
               name, slip_req, block_lock, hi_ber, slip_count, req, lock, hi, sc);
    end
  endtask

  task automatic do_reset();
    valid = 1'b0; sh_valid = 1'b0; slip_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 1'b0, 7'd0);
    reset = 1'b0;
  endtask

  initial begin
    //           v     s     a     n   req   lock  hi    sc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 63, 1'b0, 1'b0, 1'b0, 7'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 49, 1'b0, 1'b1, 1'b0, 7'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b1, 7'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 7'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0,  4, 1'b1, 1'b0, 1'b0, 7'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0,  2, 1'b1, 1'b0, 1'b0, 7'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 7'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 7'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 7'd1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 63, 1'b0, 1'b0, 1'b0, 7'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0, 7'd1};
    tbl[13] = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 7'd0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++) blk(tbl[i].v, tbl[i].s, tbl[i].a);
      check($sformatf("tbl[%0d]", i), tbl[i].req, tbl[i].lock, tbl[i].hi, tbl[i].sc);
    end

    // Bad header on block 10 in HUNT, late ack, settle, relock
    do_reset();
    for (int k = 0; k < 9; k++) blk(1'b1, 1'b1, 1'b0);
    blk(1'b1, 1'b0, 1'b0);
    check("hunt_bad_blk10", 1'b1, 1'b0, 1'b0, 7'd0);
    for (int k = 0; k < 5; k++) blk(1'b0, 1'b0, 1'b0);
    check("slip_held", 1'b1, 1'b0, 1'b0, 7'd0);
    blk(1'b0, 1'b0, 1'b1);
    check("slip_acked", 1'b0, 1'b0, 1'b0, 7'd1);
    for (int k = 0; k < 65; k++) blk(1'b1, 1'b1, 1'b0);
    check("relock_minus1", 1'b0, 1'b0, 1'b0, 7'd1);
    blk(1'b1, 1'b1, 1'b0);
    check("relock", 1'b0, 1'b1, 1'b0, 7'd0);

    // BER window of 100 with invalid headers on blocks 0,6,..,90
    for (int i = 0; i < 100; i++) begin
      blk(1'b1, !((i % 6 == 0) && i <= 90), 1'b0);
      if (i == 89) check("ber_15_bad", 1'b0, 1'b1, 1'b0, 7'd0);
      if (i == 90) check("ber_16_bad", 1'b0, 1'b1, 1'b1, 7'd0);
    end
    check("ber_win1_end", 1'b0, 1'b1, 1'b1, 7'd0);
    for (int k = 0; k < 99; k++) blk(1'b1, 1'b1, 1'b0);
    check("ber_win2_held", 1'b0, 1'b1, 1'b1, 7'd0);
    blk(1'b1, 1'b1, 1'b0);
    check("ber_win2_clean", 1'b0, 1'b1, 1'b0, 7'd0);

    // 66 slips without lock: slip_count sweeps to 65 then wraps
    do_reset();
    for (int it = 1; it <= 66; it++) begin
      blk(1'b1, 1'b0, 1'b0);
      if (it == 1) check("sweep_first_slip", 1'b1, 1'b0, 1'b0, 7'd0);
      blk(1'b0, 1'b0, 1'b1);
      blk(1'b1, 1'b1, 1'b0);
      blk(1'b1, 1'b1, 1'b0);
      if (it == 65) check("sweep_65", 1'b0, 1'b0, 1'b0, 7'd65);
      if (it == 66) check("sweep_wrap", 1'b0, 1'b0, 1'b0, 7'd0);
    end

    // Reset mid-SLIP drops slip_req asynchronously; later ack ignored
    blk(1'b1, 1'b0, 1'b0);
    check("slip_before_rst", 1'b1, 1'b0, 1'b0, 7'd0);
    valid = 1'b0; sh_valid = 1'b1;
    #1 reset = 1'b1;
    #1 check("async_rst", 1'b0, 1'b0, 1'b0, 7'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    blk(1'b0, 1'b0, 1'b1);
    check("ack_after_rst", 1'b0, 1'b0, 1'b0, 7'd0);
    blk(1'b1, 1'b0, 1'b0);
    check("hunt_after_rst", 1'b1, 1'b0, 1'b0, 7'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
